mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single-outstanding memory port; optional MEM_ARB_RR_EN selects round-robin.
// Latency: grant 1 cycle after req in IDLE; done 2 cycles (write) / 3 cycles (read) after req at best.
// Backpressure: m_ready stalls ISSUE, m_rvalid gates WAIT; requests are sampled only while IDLE.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  // fetch requester (read only)
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  // data requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wmask,
  output logic              d_gnt,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  // memory side
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wmask,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [31:0]       m_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state;
  logic   owner;   // 1 = data requester owns the transaction, 0 = fetch
  logic   pick_d;  // arbitration result for the current IDLE cycle

`ifdef MEM_ARB_RR_EN
  logic rr_data_last;  // 1 = data was granted last, 0 = fetch was granted last

  // Round-robin: on a tie the requester not granted last wins.
  always_comb begin
    pick_d = d_req && (!if_req || !rr_data_last);
  end

  // Remember who won every grant; reset leaves fetch as last so data wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_data_last <= 1'b0;
    end else if (state == IDLE && (if_req || d_req)) begin
      rr_data_last <= pick_d;
    end
  end
`else
  // Fixed priority: data always beats fetch.
  always_comb begin
    pick_d = d_req;
  end
`endif

  // Main FSM: grant, issue until accepted, wait for read data, pulse done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      owner    <= 1'b0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_wmask  <= 4'b0000;
      if_gnt   <= 1'b0;
      d_gnt    <= 1'b0;
      if_done  <= 1'b0;
      d_done   <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if_gnt  <= 1'b0;
      d_gnt   <= 1'b0;
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            owner <= pick_d;
            m_req <= 1'b1;
            state <= ISSUE;
            if (pick_d) begin
              d_gnt   <= 1'b1;
              m_we    <= d_we;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              m_wmask <= d_wmask;
            end else begin
              if_gnt  <= 1'b1;
              m_we    <= 1'b0;
              m_addr  <= if_addr;
              m_wdata <= '0;
              m_wmask <= 4'b0000;
            end
          end
        end
        ISSUE: begin
          if (m_ready) begin
            m_req <= 1'b0;
            if (m_we) begin
              // writes complete on acceptance
              if (owner) d_done  <= 1'b1;
              else       if_done <= 1'b1;
              state <= IDLE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (m_rvalid) begin
            if (owner) begin
              d_rdata <= m_rdata;
              d_done  <= 1'b1;
            end else begin
              if_rdata <= m_rdata;
              if_done  <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level reference model.
// Each transaction's expected grant, issue window, done cycle and rdata follow from the arbitration rule and chosen delays.
// Memory-side noise (m_rvalid outside WAIT, m_ready outside ISSUE) and stray requests while busy must be ignored.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req, if_gnt, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_done;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wmask;
  logic        m_req, m_we, m_ready, m_rvalid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wmask;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit          fetch_last;   // round-robin memory: fetch granted last
  logic [31:0] exp_if_rd;
  logic [31:0] exp_d_rd;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    fetch_last = 1'b1;
    exp_if_rd  = '0;
    exp_d_rd   = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {m_req, m_we, if_gnt, d_gnt, if_done, d_done}, 0);
    chk({tag, "_maddr"}, m_addr, 0);
    chk({tag, "_mwdata"}, m_wdata, 0);
    chk({tag, "_mwmask"}, m_wmask, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  task automatic chk_rdata(input string tag);
    chk({tag, "_if_rdata"}, if_rdata, exp_if_rd);
    chk({tag, "_d_rdata"}, d_rdata, exp_d_rd);
  endtask

  // drive reqs during a busy transaction: held, or random noise that must be ignored
  task automatic busy_reqs(input bit hold);
    if (!hold) begin
      if_req = 1'($urandom % 2);
      d_req  = 1'($urandom % 2);
    end
    if_addr = $urandom;
    d_addr  = $urandom;
    d_wdata = $urandom;
    d_wmask = 4'($urandom);
    d_we    = 1'($urandom % 2);
  endtask

  task automatic do_reset();
    if_req   = 1'b0;
    d_req    = 1'b0;
    m_ready  = 1'b0;
    m_rvalid = 1'b0;
    reset_n  = 1'b0;
    #1;
    model_reset();
    chk_all_zero("reset");
    step();
    step();
    reset_n = 1'b1;
  endtask

  // One transaction, entered and left just after an edge with the arbiter idle.
  task automatic run_txn(input bit fr, input bit dr, input bit dwe,
                         input logic [31:0] fa, input logic [31:0] da,
                         input logic [31:0] wd, input logic [3:0] wm,
                         input int rdy, input int rv, input logic [31:0] rd, input bit hold);
    bit          win_d;
    bit          is_wr;
    logic [31:0] ea;
    logic [3:0]  em;
    win_d = (fr && dr) ? (RR ? fetch_last : 1'b1) : dr;
    fetch_last = !win_d;
    is_wr = win_d && dwe;
    ea    = win_d ? da : fa;
    em    = win_d ? wm : 4'b0000;

    // request cycle (arbiter idle, rvalid noise must be ignored)
    if_req = fr; d_req = dr; d_we = dwe;
    if_addr = fa; d_addr = da; d_wdata = wd; d_wmask = wm;
    m_ready = 1'b0; m_rvalid = 1'($urandom % 2); m_rdata = $urandom;
    step();
    chk("if_gnt", if_gnt, !win_d);
    chk("d_gnt", d_gnt, win_d);

    // issue window: rdy stalled cycles then acceptance
    for (int i = 0; i <= rdy; i++) begin
      if (i > 0) chk("gnt_busy", {if_gnt, d_gnt}, 0);
      chk("issue_done", {if_done, d_done}, 0);
      chk("m_req", m_req, 1);
      chk("m_addr", m_addr, ea);
      chk("m_we", m_we, is_wr);
      chk("m_wmask", m_wmask, em);
      if (win_d) chk("m_wdata", m_wdata, wd);
      chk_rdata("issue");
      busy_reqs(hold);
      m_ready = (i == rdy); m_rvalid = 1'($urandom % 2); m_rdata = $urandom;
      step();
    end
    m_ready = 1'b0;

    if (!is_wr) begin
      for (int j = 0; j <= rv; j++) begin
        chk("wait_m_req", m_req, 0);
        chk("wait_pulses", {if_gnt, d_gnt, if_done, d_done}, 0);
        chk_rdata("wait");
        busy_reqs(hold);
        m_ready = 1'($urandom % 2);
        m_rvalid = (j == rv);
        m_rdata = (j == rv) ? rd : $urandom;
        step();
      end
      if (win_d) exp_d_rd = rd;
      else       exp_if_rd = rd;
    end

    // completion cycle: arbiter is idle again
    chk("if_done", if_done, !win_d);
    chk("d_done", d_done, win_d);
    chk("done_gnt", {if_gnt, d_gnt}, 0);
    chk("done_m_req", m_req, 0);
    chk_rdata("done");
    m_ready = 1'b0;
    m_rvalid = 1'b0;
    if (!hold) begin
      if_req = 1'b0;
      d_req  = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    if_addr = '0; d_addr = '0; d_wdata = '0; d_wmask = '0; d_we = 1'b0; m_rdata = '0;
    do_reset();
    step();
    chk_all_zero("post_reset");

    // fetch read, immediate ready/rvalid
    run_txn(1, 0, 0, 32'h10, 32'h0, 32'h0, 4'h0, 0, 0, 32'hDEADBEEF, 0);
    // data write stalled 3 cycles
    run_txn(0, 1, 1, 32'h0, 32'h40, 32'h12345678, 4'b0011, 3, 0, 32'h0, 0);

    // tie from reset, both held: fixed D,D,D or round-robin D,F,D
    do_reset();
    for (int k = 0; k < 3; k++)
      run_txn(1, 1, 1, 32'h100 + k, 32'h200 + k, 32'hA0 + k, 4'hF, 0, 0, 32'h55 + k, 1);
    if_req = 1'b0; d_req = 1'b0;
    step();

    // reset while waiting for read data, then a late rvalid
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    step();
    chk("rst_wait_gnt", d_gnt, 1);
    d_req = 1'b0; m_ready = 1'b1;
    step();
    chk("rst_wait_mreq", m_req, 0);
    m_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_all_zero("rst_wait");
    step();
    reset_n = 1'b1;
    m_rvalid = 1'b1; m_rdata = 32'hBADBAD00;
    step();
    chk_all_zero("late_rvalid");
    m_rvalid = 1'b0;
    step();
    run_txn(0, 1, 0, 32'h0, 32'h84, 32'h0, 4'h0, 1, 2, 32'hCAFEF00D, 0);

    // back-to-back data writes with d_req held
    for (int k = 0; k < 4; k++)
      run_txn(0, 1, 1, 32'h0, 32'h300 + 4 * k, $urandom, 4'($urandom), 0, 0, 32'h0, 1);
    d_req = 1'b0;

    // randomized traffic
    for (int k = 0; k < 80; k++) begin
      logic [1:0] pat;
      pat = 2'($urandom_range(1, 3));
      run_txn(pat[0], pat[1], 1'($urandom % 2), $urandom, $urandom, $urandom, 4'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'($urandom % 2));
    end
    if_req = 1'b0; d_req = 1'b0;

    // quiet tail: nothing requested, nothing happens
    for (int k = 0; k < 3; k++) begin
      step();
      chk("tail_quiet", {m_req, if_gnt, d_gnt, if_done, d_done}, 0);
      chk_rdata("tail");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
